// File: rtl/pcie_rx_monitor_pkg.sv
// Shared types for the PCIe RX monitor: FSM states, skid entry, register bank and its reset value.
package pcie_rx_monitor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } skid_entry_t;

  typedef struct packed {
    state_e      state;
    logic [10:0] cnt;
    logic [10:0] expected;
    logic        err;
    logic        stall;
    logic        dbg_valid;
    logic [63:0] dbg_payload;
  } pcie_rx_monitor_registers;

  localparam pcie_rx_monitor_registers pcie_rx_monitor_r_reset = '{
    state:       IDLE,
    cnt:         11'd0,
    expected:    11'd0,
    err:         1'b0,
    stall:       1'b0,
    dbg_valid:   1'b0,
    dbg_payload: 64'd0
  };

  // Beats a TLP should occupy on the 64-bit bus; a length field of 0 means 1024 DW.
  function automatic logic [10:0] expected_beats(input logic [9:0] len,
                                                 input logic       hdr4,
                                                 input logic       has_data);
    logic [10:0] len_dw;
    logic [10:0] total_dw;
    len_dw   = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    total_dw = (hdr4 ? 11'd4 : 11'd3) + (has_data ? len_dw : 11'd0);
    return (total_dw + 11'd1) >> 1;
  endfunction

endpackage

// File: rtl/pcie_skid2.sv
// Two-entry valid/ready FIFO skid buffer; ready and valid decode straight from the occupancy register.
module pcie_skid2 #(
  parameter int W = 73
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [2];
  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign full_o      = (count_q == 2'd2);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is presented until count_q says so.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/pcie_rx_monitor.sv
// Completer-request pass-through with TLP length checking, debug header capture and DMA status nibble.
//   state | meaning
//   IDLE  | waiting for the first beat of a TLP
//   BODY  | inside a TLP, counting beats until last
module pcie_rx_monitor
  import pcie_rx_monitor_pkg::*;
#(
  parameter bit chk_en   = 1'b1,
  parameter bit dbg_last = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  input  logic [63:0] i_rx_data,
  input  logic [7:0]  i_rx_keep,
  input  logic        i_rx_last,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [63:0] o_tx_data,
  output logic [7:0]  o_tx_keep,
  output logic        o_tx_last,
  input  logic        i_err_clr,
  output logic [3:0]  o_dma_state,
  output logic        o_dbg_valid,
  output logic [63:0] o_dbg_payload
);

  pcie_rx_monitor_registers r_q, r_d;
  skid_entry_t in_ent, out_ent;
  logic        full;
  logic        in_acc;
  logic        new_err;
  logic        capture;
  logic [10:0] beats;
  logic [10:0] exp_now;

  assign in_ent = '{data: i_rx_data, keep: i_rx_keep, last: i_rx_last};

  pcie_skid2 #(.W($bits(skid_entry_t))) u_skid (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .in_valid_i  (i_rx_valid),
    .in_ready_o  (o_rx_ready),
    .in_data_i   (in_ent),
    .out_valid_o (o_tx_valid),
    .out_ready_i (i_tx_ready),
    .out_data_o  (out_ent),
    .full_o      (full)
  );

  assign o_tx_data = out_ent.data;
  assign o_tx_keep = out_ent.keep;
  assign o_tx_last = out_ent.last;
  assign in_acc    = i_rx_valid & o_rx_ready;

  always_comb begin
    r_d       = r_q;
    r_d.dbg_valid = 1'b0;
    r_d.stall = o_tx_valid & ~i_tx_ready;
    new_err   = 1'b0;
    beats     = 11'd1;
    exp_now   = expected_beats(i_rx_data[9:0], i_rx_data[29], i_rx_data[30]);
    if (r_q.state == BODY) begin
      beats   = (r_q.cnt == 11'h7FF) ? r_q.cnt : r_q.cnt + 11'd1;
      exp_now = r_q.expected;
    end
    capture = dbg_last ? i_rx_last : (r_q.state == IDLE);

    if (in_acc) begin
      r_d.cnt      = beats;
      r_d.expected = exp_now;
      r_d.state    = i_rx_last ? IDLE : BODY;
      if (i_rx_last && chk_en && (beats != exp_now)) new_err = 1'b1;
      if (capture) begin
        r_d.dbg_valid   = 1'b1;
        r_d.dbg_payload = i_rx_data;
      end
    end

    // A fresh mismatch outranks a coincident clear so no error is ever lost.
    if (i_err_clr) r_d.err = 1'b0;
    if (new_err)   r_d.err = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= pcie_rx_monitor_r_reset;
    else       r_q <= r_d;
  end

  assign o_dma_state   = {r_q.err, full, r_q.stall, (r_q.state == BODY)};
  assign o_dbg_valid   = r_q.dbg_valid;
  assign o_dbg_payload = r_q.dbg_payload;

endmodule

// File: tb/tb_pcie_rx_monitor.sv
// Directed bench for pcie_rx_monitor: stimulus pushes expected beats/captures, monitors pop and compare.
module tb_pcie_rx_monitor;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic [63:0] i_rx_data = '0;
  logic [7:0]  i_rx_keep = '0;
  logic        i_rx_last = 1'b0;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_keep;
  logic        o_tx_last;
  logic        i_err_clr = 1'b0;
  logic [3:0]  o_dma_state;
  logic        o_dbg_valid;
  logic [63:0] o_dbg_payload;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t       exp_q[$];
  logic [63:0] dbg_q[$];
  logic [63:0] bd [8];
  logic [7:0]  bk [8];
  logic        bl [8];
  logic        in_tlp = 1'b0;

  pcie_rx_monitor #(.chk_en(1'b1), .dbg_last(1'b0)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rx_valid    (i_rx_valid),
    .o_rx_ready    (o_rx_ready),
    .i_rx_data     (i_rx_data),
    .i_rx_keep     (i_rx_keep),
    .i_rx_last     (i_rx_last),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_tx_data     (o_tx_data),
    .o_tx_keep     (o_tx_keep),
    .o_tx_last     (o_tx_last),
    .i_err_clr     (i_err_clr),
    .o_dma_state   (o_dma_state),
    .o_dbg_valid   (o_dbg_valid),
    .o_dbg_payload (o_dbg_payload)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream monitor: an output accept happens on the edge following this sample.
  initial begin
    beat_t e;
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("tx_unexpected_beat", {63'd0, o_tx_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", o_tx_data, e.d);
          chk("tx_keep", {56'd0, o_tx_keep}, {56'd0, e.k});
          chk("tx_last", {63'd0, o_tx_last}, {63'd0, e.l});
        end
      end
      if (!i_rst && o_dbg_valid) begin
        if (dbg_q.size() == 0) chk("dbg_unexpected_strobe", {63'd0, o_dbg_valid}, 64'd0);
        else                   chk("dbg_payload", o_dbg_payload, dbg_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_tlp(input logic [31:0] dw0, input int nb, input logic [7:0] tag);
    for (int i = 0; i < nb; i++) begin
      bd[i] = (i == 0) ? {24'hC0FFEE, tag, dw0}
                       : {tag, 24'(i), 32'h1234_5678 ^ {24'd0, tag}};
      bl[i] = (i == nb - 1);
      bk[i] = (i == nb - 1) ? 8'h0F : 8'hFF;
    end
  endtask

  // Offers beats start..start+n-1 in order; returns how many were accepted within max_cyc cycles.
  task automatic run_seq(input int start, input int n, input int max_cyc, output int acc);
    logic rdy;
    acc = 0;
    for (int c = 0; c < max_cyc && acc < n; c++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = bd[start + acc];
      i_rx_keep  = bk[start + acc];
      i_rx_last  = bl[start + acc];
      @(negedge i_clk);
      rdy = o_rx_ready;
      @(posedge i_clk);
      #1;
      if (rdy) begin
        exp_q.push_back('{d: bd[start + acc], k: bk[start + acc], l: bl[start + acc]});
        if (!in_tlp) dbg_q.push_back(bd[start + acc]);
        in_tlp = !bl[start + acc];
        acc++;
      end
    end
    i_rx_valid = 1'b0;
    i_rx_last  = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge i_clk); #1;
    i_err_clr = 1'b1;
    @(posedge i_clk); #1;
    i_err_clr = 1'b0;
  endtask

  initial begin
    int acc;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      chk("rst_rx_ready", {63'd0, o_rx_ready}, 64'd1);
      chk("rst_tx_valid", {63'd0, o_tx_valid}, 64'd0);
      chk("rst_dma_state", {60'd0, o_dma_state}, 64'd0);
      chk("rst_dbg_valid", {63'd0, o_dbg_valid}, 64'd0);
    end
    chk("rst_dbg_payload", o_dbg_payload, 64'd0);
    @(posedge i_clk); #1;

    // 3DW MWr len=2: 5 DW -> 3 beats.
    load_tlp(32'h4000_0002, 3, 8'h01);
    run_seq(0, 1, 5, acc);
    @(negedge i_clk);
    chk("lat_tx_valid", {63'd0, o_tx_valid}, 64'd1);
    chk("mwr_in_body", {63'd0, o_dma_state[0]}, 64'd1);
    @(posedge i_clk); #1;
    run_seq(1, 2, 5, acc);
    chk("mwr_accepts", 64'(acc), 64'd2);
    @(negedge i_clk);
    chk("mwr_idle", {63'd0, o_dma_state[0]}, 64'd0);
    chk("mwr_no_err", {63'd0, o_dma_state[3]}, 64'd0);
    @(posedge i_clk); #1;

    // Same header, one beat too many.
    load_tlp(32'h4000_0002, 4, 8'h02);
    run_seq(0, 4, 8, acc);
    @(negedge i_clk);
    chk("long_err_set", {63'd0, o_dma_state[3]}, 64'd1);
    clr_pulse();
    @(negedge i_clk);
    chk("err_cleared", {63'd0, o_dma_state[3]}, 64'd0);
    @(posedge i_clk); #1;
    load_tlp(32'h4000_0002, 4, 8'h03);
    i_err_clr = 1'b1;
    run_seq(0, 4, 8, acc);
    i_err_clr = 1'b0;
    @(negedge i_clk);
    chk("err_beats_clear", {63'd0, o_dma_state[3]}, 64'd1);
    clr_pulse();
    @(negedge i_clk);
    chk("err_cleared2", {63'd0, o_dma_state[3]}, 64'd0);

    // Downstream stall: 3DW MWr len=4 -> 7 DW -> 4 beats.
    @(posedge i_clk); #1;
    i_tx_ready = 1'b0;
    load_tlp(32'h4000_0004, 4, 8'h04);
    run_seq(0, 4, 6, acc);
    chk("stall_accepts", 64'(acc), 64'd2);
    @(negedge i_clk);
    chk("stall_rx_ready", {63'd0, o_rx_ready}, 64'd0);
    chk("stall_full", {63'd0, o_dma_state[2]}, 64'd1);
    chk("stall_flag", {63'd0, o_dma_state[1]}, 64'd1);
    @(posedge i_clk); #1;
    i_tx_ready = 1'b1;
    run_seq(2, 2, 10, acc);
    chk("drain_accepts", 64'(acc), 64'd2);
    repeat (4) @(posedge i_clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_no_err", {63'd0, o_dma_state[3]}, 64'd0);

    // 4DW MRd, no data: 4 DW -> 2 beats.
    load_tlp(32'h2000_0001, 2, 8'h05);
    run_seq(0, 2, 6, acc);
    @(negedge i_clk);
    chk("mrd_ok", {63'd0, o_dma_state[3]}, 64'd0);
    @(posedge i_clk); #1;
    load_tlp(32'h2000_0001, 1, 8'h06);
    run_seq(0, 1, 6, acc);
    @(negedge i_clk);
    chk("mrd_short_err", {63'd0, o_dma_state[3]}, 64'd1);

    // Reset mid-TLP with the buffer full and the error sticky.
    @(posedge i_clk); #1;
    i_tx_ready = 1'b0;
    load_tlp(32'h4000_0002, 3, 8'h07);
    run_seq(0, 3, 4, acc);
    chk("pre_rst_accepts", 64'(acc), 64'd2);
    @(negedge i_clk);
    chk("pre_rst_state", {60'd0, o_dma_state}, 64'hF);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    exp_q.delete();
    dbg_q.delete();
    in_tlp = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_tx_valid", {63'd0, o_tx_valid}, 64'd0);
    chk("mid_rst_rx_ready", {63'd0, o_rx_ready}, 64'd1);
    chk("mid_rst_dma_state", {60'd0, o_dma_state}, 64'd0);
    @(posedge i_clk); #1;
    i_tx_ready = 1'b1;
    load_tlp(32'h2000_0001, 2, 8'h08);
    run_seq(0, 2, 6, acc);
    @(negedge i_clk);
    chk("post_rst_no_err", {63'd0, o_dma_state[3]}, 64'd0);
    repeat (4) @(posedge i_clk);
    #1;
    chk("final_tx_empty", 64'(exp_q.size()), 64'd0);
    chk("final_dbg_empty", 64'(dbg_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_rx_monitor.md
Name: pcie_rx_monitor

Overview:
- Sits between the PCIe endpoint completer-request AXI-stream (64-bit) and the DMA engine.
- Passes TLP beats through a 2-entry skid buffer without modification.
- Parses each TLP header, checks beat count against the header length, and produces the brief DMA state nibble and the per-TLP debug capture (valid pulse plus 64-bit header beat).
- These outputs feed the APB PCIe control/debug register block.

Parameters:
- chk_en, 1, 1 enables the length check; 0 forces error bit to 0.
- dbg_last, 0, 0 captures beat 0 of each TLP; 1 captures the last beat instead.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; synchronous, active-high
- i_rx_valid  in  1  upstream beat valid
- o_rx_ready  out  1  upstream ready
- i_rx_data  in  64  upstream beat (DW0 in [31:0])
- i_rx_keep  in  8  byte enables
- i_rx_last  in  1  last beat of TLP
- o_tx_valid  out  1  downstream beat valid
- i_tx_ready  in  1  downstream ready
- o_tx_data  out  64  downstream beat
- o_tx_keep  out  8  downstream byte enables
- o_tx_last  out  1  downstream last
- i_err_clr  in  1  clears sticky error
- o_dma_state  out  4  brief state, see Behaviour
- o_dbg_valid  out  1  one-cycle capture strobe
- o_dbg_payload  out  64  captured beat

Behaviour:
- Reset values, applied when i_rst=1 at a clock edge:
  - skid count=0, so o_tx_valid=0 and o_rx_ready=1 from the first cycle after reset.
  - FSM=IDLE; beat counter=0; expected=0; sticky err=0.
  - o_dbg_valid=0; o_dbg_payload=0; o_dma_state=4'h0.
- Reset mid-packet: the partial TLP is discarded and the buffer is emptied. The next accepted beat is treated as a TLP start.
- Accept: input accept = i_rx_valid & o_rx_ready. Output accept = o_tx_valid & i_tx_ready.
- Skid buffer:
  - 2 entries {data, keep, last}. o_rx_ready = (count!=2), driven from registers only. o_tx_valid = (count!=0). Order is FIFO.
  - Latency is 1 cycle: a beat accepted at edge N is presented at o_tx_* after edge N.
  - Simultaneous accept in and out keeps count unchanged. With count=2 the input is never accepted.
  - Back-to-back throughput is 1 beat/cycle while i_tx_ready=1.
- Monitor: operates on input accepts only.
- FSM states:
  - IDLE: awaiting the first beat of a TLP.
  - BODY: inside a TLP.
- Transitions:
  - IDLE + accept, last=0 → BODY.
  - IDLE + accept, last=1 → IDLE; this is a single-beat TLP and is checked immediately.
  - BODY + accept with last=1 → IDLE.
- First beat header decode:
  - len = DW0[9:0]; 0 means 1024.
  - hdr4 = DW0[29]; has_data = DW0[30].
  - total_dw = (hdr4 ? 4 : 3) + (has_data ? len : 0).
  - expected_beats = (total_dw+1)>>1, 11-bit unsigned.
  - The beat counter is set to 1.
- Later beats: the counter increments, saturating at 2047.
- Length check at the last beat: if chk_en and counter != expected, sticky err is set on the same edge.
- Sticky err:
  - i_err_clr=1 clears it.
  - If a clear and a new error occur on the same edge, the error wins and stays at 1.
- Debug capture:
  - dbg_last=0: on a first-beat accept, o_dbg_payload ← i_rx_data and o_dbg_valid=1 for exactly the next cycle.
  - dbg_last=1: the same capture happens on the last-beat accept instead.
  - o_dbg_payload holds its value between strobes.
- o_dma_state, all bits registered:
  - [0] = FSM==BODY.
  - [1] = o_tx_valid & ~i_tx_ready (downstream stall), registered from the previous cycle.
  - [2] = count==2.
  - [3] = sticky err.

Decomposition:
- Package pcie_rx_monitor_pkg holds:
  - FSM state localparams (IDLE=1'b0, BODY=1'b1).
  - The register struct pcie_rx_monitor_registers.
  - The reset constant pcie_rx_monitor_r_reset.
  - The skid entry struct {data, keep, last}.
- One sub-module, pcie_skid2: 2-entry valid/ready skid buffer, parameterised data width. All header parse, counting and debug logic stays in the top.

Test Plan:
- Reset then idle → o_rx_ready=1, o_tx_valid=0, o_dma_state=0, o_dbg_valid=0 for 10 cycles.
- 3DW MWr, len=2, DW0=32'h4000_0002: beats 0/1/2 with last on beat 2, i_tx_ready=1.
  - Outputs appear 1 cycle later, unchanged.
  - o_dbg_valid pulses once with payload = beat 0.
  - o_dma_state[0]=1 during the TLP; o_dma_state[3]=0.
- Same TLP but last asserted on beat 3 → o_dma_state[3]=1 after the last beat.
  - An i_err_clr pulse returns it to 0.
  - A clear coincident with a new mismatch leaves it at 1.
- i_tx_ready=0 while streaming 4 beats → exactly 2 beats accepted, o_rx_ready=0, o_dma_state[2]=1 and o_dma_state[1]=1.
  - Releasing i_tx_ready drains all beats in order with no loss or duplication.
- 4DW MRd, DW0=32'h2000_0001 (no data, expected 2 beats), single TLP sent as 2 beats → no error.
  - The same header sent as a 1-beat TLP → error set.
- Assert i_rst mid-TLP with the buffer full → next cycle count=0, FSM=IDLE, err=0.
  - A following valid 2-beat TLP passes with no error.
